// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Produces hold/clear controls for the PC and the four pipeline registers
// from mem wait, taken branches, load-use and HI/LO-vs-mul/div hazards.
// Also owns the mul/div busy down-counter and a stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MULDIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wait,
    input  logic        branch_taken,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_hilo,
    input  logic        ex_muldiv_start,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_clear,
    output logic        idex_hold,
    output logic        idex_clear,
    output logic        exmem_hold,
    output logic        exmem_clear,
    output logic        memwb_hold,
    output logic        memwb_clear,
    output logic        muldiv_accept,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [31:0] stall_cycles
);

    localparam logic [7:0] LAT_C = 8'(MULDIV_LAT);

    logic [7:0]  cnt_r;
    logic [31:0] stall_r;
    logic        accept_s;
    logic        lu_hz_s;
    logic        md_hz_s;

    assign muldiv_busy   = (cnt_r != 8'd0);
    assign muldiv_done   = (cnt_r == 8'd1);
    assign muldiv_accept = accept_s;
    assign stall_cycles  = stall_r;

    // Hazard detection: mul/div start acceptance, load-use and HI/LO conflicts.
    always_comb begin
        accept_s = 1'b0;
        lu_hz_s  = 1'b0;
        md_hz_s  = 1'b0;
        if (rst) begin
            accept_s = 1'b0;
        end else begin
            accept_s = ex_muldiv_start & ~mem_wait;
        end
        // A load into $0 never creates a real dependency.
        lu_hz_s = ex_mem_read && (ex_rt != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rt)) ||
                   (id_uses_rt && (id_rt == ex_rt)));
        // The HI/LO reader must also wait for a mul/div accepted this very cycle.
        md_hz_s = id_hilo && (muldiv_busy || accept_s);
    end

    // Prioritised pipeline control: reset, mem freeze, branch squash, bubble.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_clear  = 1'b0;
        idex_hold   = 1'b0;
        idex_clear  = 1'b0;
        exmem_hold  = 1'b0;
        exmem_clear = 1'b0;
        memwb_hold  = 1'b0;
        memwb_clear = 1'b0;
        if (rst) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            exmem_clear = 1'b1;
            memwb_clear = 1'b1;
        end else if (mem_wait) begin
            // Freeze IF..MEM; WB receives a bubble. EX-stage requests persist.
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
            memwb_clear = 1'b1;
        end else if (branch_taken) begin
            // Squash the wrong-path IF and ID instructions; PC takes the target.
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
        end else if (lu_hz_s || md_hz_s) begin
            // Hold IF/ID and insert a bubble into EX.
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_clear = 1'b1;
        end else begin
            pc_hold = 1'b0;
        end
    end

    // Mul/div busy counter: load on accept (last start wins), else count down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (accept_s) begin
            cnt_r <= LAT_C;
        end else if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Stall performance counter: counts cycles with the PC held, wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_r <= 32'd0;
        end else if (pc_hold) begin
            stall_r <= stall_r + 32'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model that
// tracks mul/div occupancy by the edge number at which a start was accepted.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wait, branch_taken, ex_mem_read;
    logic [4:0]  ex_rt, id_rs, id_rt;
    logic        id_uses_rs, id_uses_rt, id_hilo, ex_muldiv_start;
    logic        pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear;
    logic        exmem_hold, exmem_clear, memwb_hold, memwb_clear;
    logic        muldiv_accept, muldiv_busy, muldiv_done;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // model state
    int          ec = 0;
    int          acc_ec = 0;
    logic        acc_valid = 1'b0;
    logic [31:0] m_stall = 32'd0;

    hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .mem_wait(mem_wait), .branch_taken(branch_taken),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_hilo(id_hilo),
        .ex_muldiv_start(ex_muldiv_start), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .ifid_clear(ifid_clear), .idex_hold(idex_hold), .idex_clear(idex_clear),
        .exmem_hold(exmem_hold), .exmem_clear(exmem_clear), .memwb_hold(memwb_hold),
        .memwb_clear(memwb_clear), .muldiv_accept(muldiv_accept),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the rules:
    // [11]pc_hold [10]ifid_hold [9]ifid_clear [8]idex_hold [7]idex_clear
    // [6]exmem_hold [5]exmem_clear [4]memwb_hold [3]memwb_clear
    // [2]accept [1]busy [0]done
    function automatic logic [11:0] model_ctl();
        logic [11:0] r;
        logic busy, done, acc, lu, md;
        busy = acc_valid && ((ec - acc_ec) < LAT);
        done = acc_valid && ((ec - acc_ec) == LAT - 1);
        acc  = !rst && ex_muldiv_start && !mem_wait;
        lu   = ex_mem_read && (ex_rt != 5'd0) &&
               ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        md   = id_hilo && (busy || acc);
        r = 12'd0;
        r[1] = busy;
        r[0] = done;
        r[2] = acc;
        if (rst) begin
            r[9] = 1'b1; r[7] = 1'b1; r[5] = 1'b1; r[3] = 1'b1;
        end else if (mem_wait) begin
            r[11] = 1'b1; r[10] = 1'b1; r[8] = 1'b1; r[6] = 1'b1; r[3] = 1'b1;
        end else if (branch_taken) begin
            r[9] = 1'b1; r[7] = 1'b1;
        end else if (lu || md) begin
            r[11] = 1'b1; r[10] = 1'b1; r[7] = 1'b1;
        end
        return r;
    endfunction

    // Model advance: note the edge of each accepted start and count stalls.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ec        <= 0;
            acc_valid <= 1'b0;
            m_stall   <= 32'd0;
        end else begin
            logic [11:0] mv;
            mv = model_ctl();
            ec <= ec + 1;
            if (mv[2]) begin
                acc_valid <= 1'b1;
                acc_ec    <= ec + 1;
            end
            if (mv[11]) m_stall <= m_stall + 32'd1;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ctl_vector",
                  {20'd0, pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
                   exmem_hold, exmem_clear, memwb_hold, memwb_clear,
                   muldiv_accept, muldiv_busy, muldiv_done},
                  {20'd0, model_ctl()});
            check("stall_cycles", stall_cycles, m_stall);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] pipe();
        return {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
                exmem_hold, exmem_clear, memwb_hold, memwb_clear};
    endfunction

    task automatic idle_inputs();
        mem_wait = 1'b0; branch_taken = 1'b0; ex_mem_read = 1'b0;
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_hilo = 1'b0; ex_muldiv_start = 1'b0;
    endtask

    logic [5:0] ph, bz, dn, ac;

    initial begin
        idle_inputs();
        rst = 1'b0;
        #2 rst = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_pipe", {23'd0, pipe()}, {23'd0, 9'b001010101});
        check("rst_stall", stall_cycles, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        #1 check("idle_pipe", {23'd0, pipe()}, 32'd0);

        // load-use: lw $5 in EX, add $6,$5,$1 in ID
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        id_rt = 5'd1; id_uses_rt = 1'b1;
        #1 check("lu_bubble", {23'd0, pipe()}, {23'd0, 9'b110010000});
        tick();
        ex_mem_read = 1'b0;
        #1 check("lu_after", {23'd0, pipe()}, 32'd0);
        check("lu_stall_cnt", stall_cycles, 32'd1);

        // no stall when the load targets $0 or rs is not used
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 check("lu_rt0", {23'd0, pipe()}, 32'd0);
        tick();
        ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
        #1 check("lu_rs_unused", {23'd0, pipe()}, 32'd0);
        tick();
        id_rt = 5'd5;
        #1 check("lu_rt_path", {23'd0, pipe()}, {23'd0, 9'b110010000});
        branch_taken = 1'b1;
        #1 check("branch_over_lu", {23'd0, pipe()}, {23'd0, 9'b001010000});
        mem_wait = 1'b1;
        #1 check("memwait_over_br", {23'd0, pipe()}, {23'd0, 9'b110101001});
        tick();
        idle_inputs();
        #1 check("stall_cnt_2", stall_cycles, 32'd2);

        // mul/div accepted with mfhi in ID in the same cycle
        ph = 6'b011111; bz = 6'b011110; dn = 6'b010000; ac = 6'b000001;
        ex_muldiv_start = 1'b1; id_hilo = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) ex_muldiv_start = 1'b0;
            #1;
            check($sformatf("md_pc_hold_%0d", i), {31'd0, pc_hold}, {31'd0, ph[i]});
            check($sformatf("md_busy_%0d", i), {31'd0, muldiv_busy}, {31'd0, bz[i]});
            check($sformatf("md_done_%0d", i), {31'd0, muldiv_done}, {31'd0, dn[i]});
            check($sformatf("md_accept_%0d", i), {31'd0, muldiv_accept}, {31'd0, ac[i]});
            tick();
        end
        id_hilo = 1'b0;
        #1 check("stall_cnt_7", stall_cycles, 32'd7);

        // start while memory waits 3 cycles
        ex_muldiv_start = 1'b1; mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mw_accept_%0d", i), {31'd0, muldiv_accept}, 32'd0);
            check($sformatf("mw_wbclr_%0d", i), {31'd0, memwb_clear}, 32'd1);
            tick();
        end
        mem_wait = 1'b0;
        #1 check("mw_accept_rel", {31'd0, muldiv_accept}, 32'd1);
        tick();
        ex_muldiv_start = 1'b0;
        #1 check("mw_busy", {31'd0, muldiv_busy}, 32'd1);
        check("mw_done_early", {31'd0, muldiv_done}, 32'd0);
        check("stall_cnt_10", stall_cycles, 32'd10);
        repeat (4) tick();
        #1 check("mw_idle", {31'd0, muldiv_busy}, 32'd0);

        // asynchronous reset while the counter holds 2
        ex_muldiv_start = 1'b1;
        tick();
        ex_muldiv_start = 1'b0;
        tick();
        tick();
        #1 check("pre_rst_busy", {31'd0, muldiv_busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, muldiv_busy}, 32'd0);
        check("arst_stall", stall_cycles, 32'd0);
        check("arst_pipe", {23'd0, pipe()}, {23'd0, 9'b001010101});
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("arst_no_done_%0d", i), {30'd0, muldiv_busy, muldiv_done}, 32'd0);
            tick();
        end

        // mixed vectors, checked every cycle by the model
        for (int i = 0; i < 300; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            mem_wait        = ($urandom_range(0, 3) == 0);
            branch_taken    = ($urandom_range(0, 5) == 0);
            ex_mem_read     = ($urandom_range(0, 1) == 0);
            ex_rt           = 5'($urandom_range(0, 3));
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rs      = ($urandom_range(0, 1) == 0);
            id_uses_rt      = ($urandom_range(0, 1) == 0);
            id_hilo         = ($urandom_range(0, 3) == 0);
            ex_muldiv_start = ($urandom_range(0, 4) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (LAT + 2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB). It generates the `hold` and `clear` controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions: data-memory wait, taken branches, load-use hazards, and ID-stage accesses to HI/LO while the multi-cycle mul/div unit is busy. It owns the mul/div busy counter and a stall-cycle performance counter.

## Interface
Parameters:
- `MULDIV_LAT`, default 32: mul/div latency in cycles. Legal range 1..255.

Ports:
- `clk`: input, 1 bit. Core clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `mem_wait`: input, 1 bit. Data memory not ready for the instruction in MEM.
- `branch_taken`: input, 1 bit. Branch or jump in EX resolved taken.
- `ex_mem_read`: input, 1 bit. Instruction in EX is a load.
- `ex_rt`: input, 5 bits. Destination register of the load in EX.
- `id_rs`, `id_rt`: input, 5 bits each. Source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`: input, 1 bit each. ID instruction actually reads rs / rt.
- `id_hilo`: input, 1 bit. ID instruction reads HI/LO (mfhi/mflo) or is itself a mul/div.
- `ex_muldiv_start`: input, 1 bit. Mul/div instruction in EX requests start.
- `pc_hold`, `ifid_hold`, `ifid_clear`, `idex_hold`, `idex_clear`, `exmem_hold`, `exmem_clear`, `memwb_hold`, `memwb_clear`: output, 1 bit each. Pipeline register controls.
- `muldiv_accept`: output, 1 bit. Start accepted this cycle.
- `muldiv_busy`: output, 1 bit. Mul/div counter nonzero.
- `muldiv_done`: output, 1 bit. HI/LO are written at this edge.
- `stall_cycles`: output, 32 bits. Count of cycles with `pc_hold`=1.

## Operation
State:
- `cnt[7:0]`: mul/div down-counter.
- `stall_cycles[31:0]`.
- Outputs are combinational from inputs and state. Every pipe register samples them at the same edge.

Derived signals:
- `muldiv_accept` = `ex_muldiv_start` & !`mem_wait`.
- `muldiv_busy` = (`cnt` != 0).
- `muldiv_done` = (`cnt` == 1).
- `lu_hz` = `ex_mem_read` & (`ex_rt` != 0) & ((`id_uses_rs` & `id_rs`==`ex_rt`) | (`id_uses_rt` & `id_rt`==`ex_rt`)).
- `md_hz` = `id_hilo` & (`muldiv_busy` | `muldiv_accept`).

Priority (first match wins; every output not listed is 0):
1. `rst`=1: `ifid_clear`=`idex_clear`=`exmem_clear`=`memwb_clear`=1. All holds are 0, `muldiv_accept`=0.
2. `mem_wait`: `pc_hold`=`ifid_hold`=`idex_hold`=`exmem_hold`=1 and `memwb_clear`=1 (bubble into WB).
   - `branch_taken` and `ex_muldiv_start` are ignored; they persist because EX is held.
3. `branch_taken`: `ifid_clear`=`idex_clear`=1. The PC loads the target and is not held.
   - Overrides `lu_hz` and `md_hz`, since the ID instruction is squashed.
4. `lu_hz` or `md_hz`: `pc_hold`=`ifid_hold`=1 and `idex_clear`=1 (bubble into EX).
5. Otherwise all outputs are 0.

Mul/div counter:
- On `muldiv_accept`, `cnt` loads `MULDIV_LAT`.
- Otherwise, if `cnt` != 0, it decrements. It keeps decrementing during `mem_wait`.
- A start cannot be accepted while busy: an ID mul/div is stalled by `md_hz`. If `ex_muldiv_start` arrives while busy anyway, it reloads `cnt` (last start wins).
- `stall_cycles` increments on every edge where `pc_hold`=1 and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: `cnt`=0 and `stall_cycles`=0 immediately on `rst` rising, without waiting for a clock edge. After release, all outputs are 0 until inputs change.
- Control latency is 0 cycles: a hazard present in cycle N asserts its outputs in cycle N, so the registers act at the end of cycle N.
- Load-use costs exactly 1 bubble. In the next cycle the load is in MEM, so `lu_hz` drops.
- Mul/div timing, with acceptance at edge E0:
  - `muldiv_busy`=1 for the `MULDIV_LAT` cycles after E0.
  - `muldiv_done`=1 in the last of those cycles.
  - An ID HI/LO reader present at acceptance stalls `MULDIV_LAT`+1 cycles in total.
- `mem_wait` for K cycles freezes IF–EX for K cycles and inserts K WB bubbles.
- `rst` asserted mid-multiply aborts it: `cnt`=0 and no `muldiv_done` is issued.

## Test plan
- Load `lw $5` in EX with ID `add $6,$5,$1` (`id_uses_rs`=1) -> one cycle of `pc_hold`=`ifid_hold`=`idex_clear`=1, then all 0. `stall_cycles` goes 0→1.
- Same as above but `ex_rt`=0 or `id_uses_rs`=0 -> no stall.
- `branch_taken` together with `lu_hz`=1 -> `ifid_clear`=`idex_clear`=1, `pc_hold`=0. With `mem_wait` added in the same cycle -> freeze outputs only.
- `MULDIV_LAT`=4, start accepted, mfhi in ID in the same cycle -> `pc_hold` for 5 cycles. `muldiv_busy` high for 4 cycles. `muldiv_done` high in the 4th. mfhi proceeds in the 6th.
- `ex_muldiv_start` with `mem_wait` held 3 cycles -> `muldiv_accept`=0 for 3 cycles, then 1 once, then `cnt`=`MULDIV_LAT`. `memwb_clear`=1 for the 3 cycles.
- Assert `rst` asynchronously between edges while `cnt`=2 -> `cnt`, `muldiv_busy` and `stall_cycles` go to 0 at once; all clears are 1 while `rst`=1.
